// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared defaults and grant encoding for the memory port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int c_WIDTH_DEFAULT     = 2;
    localparam int c_PSIZE_DEFAULT     = 2;
    localparam int c_RSP_DEPTH_DEFAULT = 2;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rsp_fifo
//  Brief    : Synchronous response FIFO with push/pop and occupancy count.
//  Revision : 1.0  initial release
// ============================================================================
module rsp_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEFAULT,
    parameter int RSP_DEPTH = c_RSP_DEPTH_DEFAULT,
    parameter int CNT_W     = cnt_width(RSP_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [RSP_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Round-robin write/read merge onto a single-port-pair memory with
//             credit-limited reads and a buffered read-response stream.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH_DEFAULT,
    parameter int PSIZE     = c_PSIZE_DEFAULT,
    parameter int RSP_DEPTH = c_RSP_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [PSIZE-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_valid_i,
    output logic             rd_ready_o,
    input  logic [PSIZE-1:0] rd_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             mem_wr_o,
    output logic             mem_rd_o,
    output logic [PSIZE-1:0] mem_wr_addr_o,
    output logic [PSIZE-1:0] mem_rd_addr_o,
    output logic [WIDTH-1:0] mem_wr_data_o,
    input  logic [WIDTH-1:0] mem_rd_data_i
);

    localparam int c_CNT_W = cnt_width(RSP_DEPTH);

    logic               last_wr_q, last_wr_d;
    logic               inflight_q;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W:0]   w_occupancy;
    logic               w_rd_ok;
    logic               w_rd_req;
    logic               w_wr_gnt;
    logic               w_rd_gnt;
    logic               w_pop;
    gnt_t               w_tie_gnt;

    // In-flight read already owns a slot, so it counts against the credit.
    assign w_occupancy = {1'b0, w_count} + {{c_CNT_W{1'b0}}, inflight_q};
    assign w_rd_ok     = w_occupancy < (c_CNT_W + 1)'(RSP_DEPTH);
    assign w_rd_req    = rd_valid_i && w_rd_ok;
    assign w_tie_gnt   = last_wr_q ? GNT_RD : GNT_WR;

    always_comb begin
        w_wr_gnt  = 1'b0;
        w_rd_gnt  = 1'b0;
        last_wr_d = last_wr_q;
        if (!rst) begin
            if (wr_valid_i && w_rd_req) begin
                w_wr_gnt = (w_tie_gnt == GNT_WR);
                w_rd_gnt = (w_tie_gnt == GNT_RD);
            end else begin
                w_wr_gnt = wr_valid_i;
                w_rd_gnt = w_rd_req;
            end
        end
        if (w_wr_gnt) begin
            last_wr_d = 1'b1;
        end else if (w_rd_gnt) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            last_wr_q  <= last_wr_d;
            inflight_q <= w_rd_gnt;
        end
    end

    assign w_pop = rsp_valid_o && rsp_ready_i;

    rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (c_CNT_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_rd_data_i),
        .pop_i       (w_pop),
        .head_o      (rsp_data_o),
        .count_o     (w_count)
    );

    assign rsp_valid_o   = (w_count != '0) && !rst;
    assign wr_ready_o    = w_wr_gnt;
    assign rd_ready_o    = w_rd_gnt;
    assign mem_wr_o      = w_wr_gnt;
    assign mem_rd_o      = w_rd_gnt;
    assign mem_wr_addr_o = wr_addr_i;
    assign mem_rd_addr_o = rd_addr_i;
    assign mem_wr_data_o = wr_data_i;

    a_port_exclusive : assert property (@(posedge clk) disable iff (rst) !(mem_wr_o && mem_rd_o));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench: arbiter plus a behavioural memory
//             that swaps the two data bits for the upper half of the array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, rd_valid, rsp_ready;
    logic [1:0] wr_addr, wr_data, rd_addr;
    logic       wr_ready, rd_ready, rsp_valid, mem_wr, mem_rd;
    logic [1:0] rsp_data, mem_wr_addr, mem_rd_addr, mem_wr_data, mem_rd_data;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [1:0] exp_q[$];
    logic [1:0] sb_mem[4];
    logic [1:0] mem_arr[4];

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(2), .PSIZE(2), .RSP_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_valid_i    (rd_valid),
        .rd_ready_o    (rd_ready),
        .rd_addr_i     (rd_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .mem_wr_o      (mem_wr),
        .mem_rd_o      (mem_rd),
        .mem_wr_addr_o (mem_wr_addr),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_data_i (mem_rd_data)
    );

    // Memory: 1-cycle read latency, upper-half addresses return bit-swapped data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem_arr[i] <= 2'b00;
            mem_rd_data <= 2'b00;
        end else begin
            if (mem_wr) mem_arr[mem_wr_addr] <= mem_wr_data;
            if (mem_rd) mem_rd_data <= mem_rd_addr[1] ? {mem_arr[mem_rd_addr][0], mem_arr[mem_rd_addr][1]}
                                                      : mem_arr[mem_rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected data queued on read accept, compared on response pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) sb_mem[i] = 2'b00;
        end else begin
            chk("mutex", {7'b0, mem_wr & mem_rd}, 8'h00);
            if (wr_ready) sb_mem[wr_addr] = wr_data;
            if (rd_ready)
                exp_q.push_back(rd_addr[1] ? {sb_mem[rd_addr][0], sb_mem[rd_addr][1]} : sb_mem[rd_addr]);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 8'h01, 8'h00);
                else                   chk("rsp_order", {6'b0, rsp_data}, {6'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd;
        int n_wr;
        int waited;
        rst = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        wr_addr = 2'd0; wr_data = 2'd0; rd_addr = 2'd0;
        tick();
        @(negedge clk);
        chk("rst_ready", {6'b0, wr_ready, rd_ready}, 8'h00);
        chk("rst_mem", {6'b0, mem_wr, mem_rd}, 8'h00);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        tick();
        rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

        // Write then read back, checking two-cycle response latency.
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 2'b10;
        @(negedge clk); chk("t1_wr_ready", {7'b0, wr_ready}, 8'h01);
        tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 2'd1;
        @(negedge clk); chk("t1_rd_ready", {7'b0, rd_ready}, 8'h01);
        tick(); rd_valid = 1'b0;
        @(negedge clk); chk("t1_lat1", {7'b0, rsp_valid}, 8'h00);
        tick();
        @(negedge clk); chk("t1_lat2", {7'b0, rsp_valid}, 8'h01);
        chk("t1_data", {6'b0, rsp_data}, 8'h02);
        tick();

        // Upper-half address comes back swapped.
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 2'b01;
        @(negedge clk); tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 2'd3;
        @(negedge clk); chk("t2_rd_ready", {7'b0, rd_ready}, 8'h01);
        tick(); rd_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!rsp_valid && waited < 6) begin
            tick(); @(negedge clk); waited++;
        end
        chk("t2_rsp_seen", {7'b0, rsp_valid}, 8'h01);
        chk("t2_data", {6'b0, rsp_data}, 8'h02);
        tick();
        tick();

        // Sustained contention alternates, starting with write.
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 2'd0; rd_addr = 2'd0;
        for (int i = 0; i < 6; i++) begin
            wr_data = i[1:0];
            @(negedge clk);
            chk((i % 2 == 0) ? "t3_grant_w" : "t3_grant_r", {6'b0, wr_ready, rd_ready},
                (i % 2 == 0) ? 8'h02 : 8'h01);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        tick(); tick(); tick();

        // Backpressure: two reads fill the buffer, writes keep flowing.
        rsp_ready = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 2'd0; rd_addr = 2'd2;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < 8; i++) begin
            wr_data = i[1:0];
            @(negedge clk);
            if (rd_ready) n_rd++;
            if (wr_ready) n_wr++;
            tick();
        end
        @(negedge clk);
        chk("t4_rd_stalled", {7'b0, rd_ready}, 8'h00);
        chk("t4_rd_count", n_rd[7:0], 8'd2);
        chk("t4_wr_count", n_wr[7:0], 8'd6);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk); chk("t4_drain1", {7'b0, rsp_valid}, 8'h01);
        tick();
        @(negedge clk); chk("t4_drain2", {7'b0, rsp_valid}, 8'h01);
        tick();
        @(negedge clk); chk("t4_empty", {7'b0, rsp_valid}, 8'h00);
        tick();

        // Reset while one read is in flight and one response is buffered.
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 2'd1;
        @(negedge clk); chk("t4_resume", {7'b0, rd_ready}, 8'h01);
        tick();
        @(negedge clk); chk("t5_rd2", {7'b0, rd_ready}, 8'h01);
        tick();
        rst = 1'b1; rd_valid = 1'b0;
        @(negedge clk); chk("t5_rst_rsp", {7'b0, rsp_valid}, 8'h00);
        tick();
        rst = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t5_no_stale", {7'b0, rsp_valid}, 8'h00);
            tick();
        end

        // Push and pop in the same cycle while one entry is held.
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 2'b01;
        @(negedge clk); tick();
        wr_addr = 2'd1; wr_data = 2'b10;
        @(negedge clk); tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 2'd0;
        @(negedge clk); chk("t6_rd_a", {7'b0, rd_ready}, 8'h01);
        tick(); rd_addr = 2'd1;
        @(negedge clk); chk("t6_rd_b", {7'b0, rd_ready}, 8'h01);
        tick(); rd_valid = 1'b0;
        @(negedge clk);
        chk("t6_first_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t6_first_data", {6'b0, rsp_data}, 8'h01);
        tick();
        @(negedge clk);
        chk("t6_second_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t6_second_data", {6'b0, rsp_data}, 8'h02);
        tick();
        @(negedge clk);
        chk("t6_empty", {7'b0, rsp_valid}, 8'h00);
        chk("sb_empty", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
